// File: rtl/button_mode_ctrl.sv
// Button debounce, short/long press detection and mode selection.
// Presents the selected mode to a transmitter over a valid/ready link.
module button_mode_ctrl #(
  parameter int DEBOUNCE_CYCLES   = 120000,
  parameter int LONG_PRESS_CYCLES = 12000000,
  parameter int NUM_MODES         = 4
) (
  input  logic       pin_clk_12mhz,
  input  logic       rst,
  input  logic       pin_user_sw,
  output logic [1:0] cfg_mode,
  output logic       cfg_valid,
  input  logic       cfg_ready,
  output logic       long_press,
  output logic       red,
  output logic       green,
  output logic       blue
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);
  localparam logic [1:0] MODE_LAST = 2'(NUM_MODES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } state_t;

  logic          sync1;
  logic          sync2;
  logic          db_level;
  logic [DW-1:0] db_cnt;
  state_t        state_q;
  state_t        state_d;
  logic [HW-1:0] hold_q;
  logic [HW-1:0] hold_d;
  logic [1:0]    mode_q;
  logic [1:0]    mode_d;
  logic          lp_d;
  logic          init;

  // Two-flop synchronizer; idles at the released level.
  always_ff @(posedge pin_clk_12mhz) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= pin_user_sw;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after it has been stable long enough.
  always_ff @(posedge pin_clk_12mhz) begin
    if (rst) begin
      db_level <= 1'b1;
      db_cnt   <= '0;
    end else if (sync2 == db_level) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      db_level <= sync2;
      db_cnt   <= '0;
    end else begin
      db_cnt <= db_cnt + DW'(1);
    end
  end

  // Press FSM, hold counter, mode and long-press pulse registers.
  always_ff @(posedge pin_clk_12mhz) begin
    if (rst) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      mode_q     <= '0;
      long_press <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      mode_q     <= mode_d;
      long_press <= lp_d;
    end
  end

  // Next state; a release on the threshold cycle counts as short.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    mode_d  = mode_q;
    lp_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        hold_d = '0;
        if (!db_level) state_d = PRESSED;
      end
      PRESSED: begin
        hold_d = hold_q + HW'(1);
        if (db_level) begin
          state_d = IDLE;
          mode_d  = (mode_q == MODE_LAST) ? 2'd0 : mode_q + 2'd1;
        end else if (hold_q == HOLD_LAST) begin
          state_d = HELD;
          lp_d    = 1'b1;
          mode_d  = 2'd0;
        end
      end
      HELD: begin
        if (db_level) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Config link: latest mode wins, always announce once after reset.
  always_ff @(posedge pin_clk_12mhz) begin
    if (rst) begin
      cfg_mode  <= '0;
      cfg_valid <= 1'b0;
      init      <= 1'b1;
    end else if (cfg_valid) begin
      if (cfg_ready) cfg_valid <= 1'b0;
    end else if (init || (mode_q != cfg_mode)) begin
      cfg_mode  <= mode_q;
      cfg_valid <= 1'b1;
      init      <= 1'b0;
    end
  end

  // Active-low LED decode; all dark while a long press is held.
  always_comb begin
    red   = 1'b1;
    green = 1'b1;
    blue  = 1'b1;
    if (state_q != HELD) begin
      unique case (mode_q)
        2'd0: red = 1'b0;
        2'd1: green = 1'b0;
        2'd2: blue = 1'b0;
        default: begin
          red   = 1'b0;
          green = 1'b0;
          blue  = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_mode_ctrl.sv
// Directed bench for button_mode_ctrl with short debounce/hold settings.
// Inputs change #1 after posedge; outputs are sampled at the same point.
module tb_button_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       pin;
  logic [1:0] cfg_mode;
  logic       cfg_valid;
  logic       rdy;
  logic       long_press;
  logic       red;
  logic       green;
  logic       blue;
  logic [2:0] leds;

  int checks = 0;
  int errors = 0;
  int lp_pulses = 0;
  logic seen;

  assign leds = {red, green, blue};

  always #5 clk = ~clk;

  button_mode_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .LONG_PRESS_CYCLES(20),
    .NUM_MODES(4)
  ) dut (
    .pin_clk_12mhz(clk),
    .rst(rst),
    .pin_user_sw(pin),
    .cfg_mode(cfg_mode),
    .cfg_valid(cfg_valid),
    .cfg_ready(rdy),
    .long_press(long_press),
    .red(red),
    .green(green),
    .blue(blue)
  );

  always @(negedge clk) begin
    if (long_press === 1'b1) lp_pulses++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Clean 10-cycle press; mode lands 17 cycles after the press starts.
  task automatic short_press(input logic [1:0] m, input logic [2:0] l);
    pin = 1'b0;
    tick(10);
    pin = 1'b1;
    tick(6);
    check("sp_pre_valid", {7'd0, cfg_valid}, 8'd0);
    tick(1);
    check("sp_leds", {5'd0, leds}, {5'd0, l});
    check("sp_valid_lo", {7'd0, cfg_valid}, 8'd0);
    tick(1);
    check("sp_valid", {7'd0, cfg_valid}, 8'd1);
    check("sp_mode", {6'd0, cfg_mode}, {6'd0, m});
    tick(1);
    check("sp_drop", {7'd0, cfg_valid}, 8'd0);
    tick(3);
  endtask

  initial begin
    rst = 1'b1;
    pin = 1'b1;
    rdy = 1'b1;
    tick(3);
    check("rst_valid", {7'd0, cfg_valid}, 8'd0);
    check("rst_mode", {6'd0, cfg_mode}, 8'd0);
    check("rst_lp", {7'd0, long_press}, 8'd0);
    check("rst_leds", {5'd0, leds}, 8'b011);

    rst = 1'b0;
    tick(1);
    check("init_valid", {7'd0, cfg_valid}, 8'd1);
    check("init_mode", {6'd0, cfg_mode}, 8'd0);
    tick(1);
    check("init_drop", {7'd0, cfg_valid}, 8'd0);
    check("init_leds", {5'd0, leds}, 8'b011);
    tick(3);

    seen = 1'b0;
    for (int r = 0; r < 3; r++) begin
      pin = 1'b0;
      for (int k = 0; k < 3; k++) begin
        tick(1);
        seen |= cfg_valid;
      end
      pin = 1'b1;
      for (int k = 0; k < 2; k++) begin
        tick(1);
        seen |= cfg_valid;
      end
    end
    for (int k = 0; k < 12; k++) begin
      tick(1);
      seen |= cfg_valid;
    end
    check("bounce_valid", {7'd0, seen}, 8'd0);
    check("bounce_mode", {6'd0, cfg_mode}, 8'd0);
    check("bounce_leds", {5'd0, leds}, 8'b011);

    short_press(2'd1, 3'b101);
    short_press(2'd2, 3'b110);
    short_press(2'd3, 3'b000);
    short_press(2'd0, 3'b011);
    short_press(2'd1, 3'b101);
    short_press(2'd2, 3'b110);

    pin = 1'b0;
    tick(26);
    check("lp_early", {7'd0, long_press}, 8'd0);
    check("lp_early_leds", {5'd0, leds}, 8'b110);
    tick(1);
    check("lp_pulse", {7'd0, long_press}, 8'd1);
    check("lp_held_leds", {5'd0, leds}, 8'b111);
    tick(1);
    check("lp_once", {7'd0, long_press}, 8'd0);
    check("lp_cfg_valid", {7'd0, cfg_valid}, 8'd1);
    check("lp_cfg_mode", {6'd0, cfg_mode}, 8'd0);
    tick(12);
    pin = 1'b1;
    check("lp_held_leds2", {5'd0, leds}, 8'b111);
    tick(6);
    check("lp_held_leds3", {5'd0, leds}, 8'b111);
    tick(1);
    check("lp_release_leds", {5'd0, leds}, 8'b011);
    tick(5);
    check("lp_after_valid", {7'd0, cfg_valid}, 8'd0);
    check("lp_after_mode", {6'd0, cfg_mode}, 8'd0);
    check("lp_count", 8'(lp_pulses), 8'd1);

    rdy = 1'b0;
    pin = 1'b0;
    tick(10);
    pin = 1'b1;
    tick(8);
    check("bp_valid1", {7'd0, cfg_valid}, 8'd1);
    check("bp_mode1", {6'd0, cfg_mode}, 8'd1);
    tick(3);
    pin = 1'b0;
    tick(10);
    pin = 1'b1;
    tick(7);
    check("bp_leds2", {5'd0, leds}, 8'b110);
    check("bp_hold_mode", {6'd0, cfg_mode}, 8'd1);
    check("bp_hold_valid", {7'd0, cfg_valid}, 8'd1);
    tick(3);
    check("bp_hold_mode2", {6'd0, cfg_mode}, 8'd1);
    rdy = 1'b1;
    tick(1);
    check("bp_drop", {7'd0, cfg_valid}, 8'd0);
    tick(1);
    check("bp_reissue", {7'd0, cfg_valid}, 8'd1);
    check("bp_mode2", {6'd0, cfg_mode}, 8'd2);
    tick(1);
    check("bp_drop2", {7'd0, cfg_valid}, 8'd0);
    tick(3);

    pin = 1'b0;
    tick(17);
    rst = 1'b1;
    pin = 1'b1;
    tick(1);
    check("mr_valid", {7'd0, cfg_valid}, 8'd0);
    check("mr_mode", {6'd0, cfg_mode}, 8'd0);
    check("mr_lp", {7'd0, long_press}, 8'd0);
    check("mr_leds", {5'd0, leds}, 8'b011);
    tick(2);
    rst = 1'b0;
    tick(1);
    check("mr_init_valid", {7'd0, cfg_valid}, 8'd1);
    check("mr_init_mode", {6'd0, cfg_mode}, 8'd0);
    tick(1);
    check("mr_init_drop", {7'd0, cfg_valid}, 8'd0);
    tick(30);
    check("mr_lp_count", 8'(lp_pulses), 8'd1);
    check("mr_end_leds", {5'd0, leds}, 8'b011);
    check("mr_end_valid", {7'd0, cfg_valid}, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_mode_ctrl.md
BUTTON_MODE_CTRL -- requirements
Module: button_mode_ctrl

Interface
REQ-001 The block SHALL have parameters:
- DEBOUNCE_CYCLES, default 120000: stable-input cycles needed to accept a button level change (10 ms at 12 MHz).
- LONG_PRESS_CYCLES, default 12000000: pressed cycles that make a long press (1 s).
- NUM_MODES, default 4, range 2..4: number of transmitter modes.
REQ-002 The block SHALL have ports:
- pin_clk_12mhz  in  1  sole clock.
- rst  in  1  reset, synchronous, active-high.
- pin_user_sw  in  1  raw button, active-low, asynchronous.
- cfg_mode  out  2  mode presented to the transmitter.
- cfg_valid  out  1  cfg_mode is valid.
- cfg_ready  in  1  transmitter accepts cfg_mode.
- long_press  out  1  one-cycle pulse when a long press is detected.
- red, green, blue  out  1 each  LED drives, active-low (0 = lit).

Function
REQ-003 pin_user_sw SHALL pass through a 2-flop synchronizer; both flops initialise to 1 (released).
REQ-004 Debounce: a counter SHALL increment every cycle the synchronized value differs from the debounced level.
- The counter SHALL clear to 0 on any cycle the values are equal.
- The debounced level SHALL take the new value, and the counter SHALL clear, on the DEBOUNCE_CYCLES-th consecutive differing cycle.
REQ-005 The press FSM SHALL have states IDLE, PRESSED and HELD.
REQ-006 IDLE -> PRESSED SHALL occur on the cycle after the debounced level falls 1->0; the hold counter SHALL clear to 0 on this transition.
REQ-007 In PRESSED, the hold counter SHALL increment every cycle.
- When it reaches LONG_PRESS_CYCLES-1 with the button still pressed, the FSM SHALL go to HELD.
- On that transition, long_press SHALL pulse for exactly 1 cycle and mode SHALL load 0.
REQ-008 PRESSED with the debounced level rising 0->1 is a short press: the FSM SHALL go to IDLE and mode SHALL load (mode+1), wrapping from NUM_MODES-1 to 0.
REQ-009 HELD with the debounced level rising SHALL go to IDLE with no mode change; the hold counter SHALL saturate while in HELD.
REQ-010 A release and the long-press threshold in the same cycle SHALL be treated as a short press: no long_press pulse, mode increments.
REQ-011 Config handshake: a transfer SHALL occur on a cycle where cfg_valid and cfg_ready are both 1.
REQ-012 While cfg_valid=1 and cfg_ready=0, cfg_mode SHALL hold stable.
REQ-013 When cfg_valid=0 and mode != cfg_mode, the next cycle SHALL load cfg_mode<=mode and set cfg_valid=1.
REQ-014 On a transfer cycle, cfg_valid SHALL drop to 0.
- If mode then differs from cfg_mode, REQ-013 SHALL re-issue the new mode one cycle later.
- Intermediate modes MAY be skipped (latest value wins).
REQ-015 cfg_ready SHALL be ignored while cfg_valid=0.
REQ-016 LEDs SHALL be decoded from the internal mode register with no extra latency; lit LEDs are driven 0:
- mode 0: red lit.
- mode 1: green lit.
- mode 2: blue lit.
- mode 3: all three lit.
REQ-017 In HELD, all LEDs SHALL be forced off (1) until release, as user feedback for the long press.
REQ-018 Counter widths SHALL be derived from the parameters (clog2) so that no counter wraps before its terminal value.

Reset
REQ-019 While rst=1, all of the following SHALL be true on the next edge:
- FSM in IDLE.
- mode=0, cfg_mode=0, cfg_valid=0, long_press=0.
- All counters 0.
- Debounced level and synchronizer flops at 1.
- LEDs: red=0, green=1, blue=1.
REQ-020 An init flag set by reset SHALL force cfg_valid=1 with cfg_mode=0 on the first cycle after rst falls, so the transmitter is always configured once after reset.
REQ-021 Asserting rst mid-press or mid-handshake SHALL abandon the press and the pending transfer with no long_press pulse.

Verification (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, NUM_MODES=4, cfg_ready=1 unless stated)
REQ-022 Reset release -> cfg_valid=1 with cfg_mode=0 for exactly 1 cycle; LEDs are red=0, green=1, blue=1.
REQ-023 Press held 3 cycles with bounces every 2 cycles, then released -> no debounced change, mode stays 0, no cfg_valid.
REQ-024 Four clean short presses (10 cycles each) -> mode sequence 1,2,3,0.
- cfg_mode SHALL present each value in turn.
- At mode 3, LEDs SHALL be 0,0,0; at the wrap they SHALL return to red only.
REQ-025 Starting at mode 2, press held 40 cycles:
- long_press pulses once, 20 cycles after the FSM enters PRESSED.
- mode becomes 0 and LEDs are all 1 until release.
- After release, red=0; no further mode change.
REQ-026 cfg_ready=0 while two short presses occur (modes 1 then 2):
- cfg_mode holds 1 with cfg_valid=1 throughout.
- When cfg_ready rises, cfg_valid drops for 1 cycle, then re-asserts with cfg_mode=2.
REQ-027 rst pulsed at hold count 10 of a long press -> no long_press pulse; all outputs take the REQ-019 reset values.
